// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial load/store initiator between the core and a byte-wide data memory.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned H/W accesses with resp_err instead of performing them.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wd,
    input  logic [7:0]            mem_rd
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, ext;
    logic [2:0]            f3_q;
    logic [1:0]            cnt_q, last_idx;
    logic                  we_q, err_q, accept, illegal, misaligned, bad, last;
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:ADDR_BITS];
    assign accept  = req_valid && state_q == IDLE;
    assign illegal = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11;
`ifdef MISALIGN_TRAP_EN
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign bad      = illegal || misaligned;
    assign last_idx = f3_q[1:0] == 2'b00 ? 2'd0 : f3_q[1:0] == 2'b01 ? 2'd1 : 2'd3;
    assign last     = cnt_q == last_idx;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // Next state: rejected requests skip ACCESS and respond directly
    always_comb begin
        state_d = state_q == IDLE   ? (req_valid ? (bad ? RESP : ACCESS) : IDLE) :
                  state_q == ACCESS ? (last ? RESP : ACCESS) :
                                      (resp_ready ? IDLE : RESP);
    end
    // Request latch, byte counter and load byte-lane capture
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr[ADDR_BITS-1:0];
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            we_q    <= req_we;
            err_q   <= bad;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 2'd1;
            if (!we_q) rdata_q[{cnt_q, 3'b000} +: 8] <= mem_rd;
        end
    end
    // Sign/zero extension of the assembled load bytes
    always_comb begin
        ext = f3_q[1:0] == 2'b00 ? {{(DATA_WIDTH-8){~f3_q[2] & rdata_q[7]}}, rdata_q[7:0]} :
              f3_q[1:0] == 2'b01 ? {{(DATA_WIDTH-16){~f3_q[2] & rdata_q[15]}}, rdata_q[15:0]} :
                                   rdata_q;
    end
    // Outputs: memory port is quiet outside ACCESS, response fields only in RESP
    always_comb begin
        req_ready  = state_q == IDLE;
        resp_valid = state_q == RESP;
        resp_err   = state_q == RESP && err_q;
        resp_rdata = (state_q == RESP && !we_q && !err_q) ? ext : '0;
        mem_addr   = state_q == ACCESS ? {{(DATA_WIDTH-ADDR_BITS){1'b0}}, addr_q + ADDR_BITS'(cnt_q)} : '0;
        mem_we     = state_q == ACCESS && we_q;
        mem_wd     = (state_q == ACCESS && we_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a byte memory model for load_store_unit.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr;
    logic [7:0]  mem_wd, mem_rd;
    logic [7:0]  mem [0:131071];
    logic [31:0] wa [64];
    logic [7:0]  wd [64];
    int          wn = 0, n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_addr[16:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[16:0]] <= mem_wd;
            if (wn < 64) begin
                wa[wn] <= mem_addr;
                wd[wn] <= mem_wd;
            end
            wn <= wn + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wdat,
                        input int hold, output logic [31:0] rd, output logic er, output int cyc);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wdat;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!resp_valid) chk("timeout", 32'd0, 32'd1);
        rd = resp_rdata;
        er = resp_err;
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, e;
        logic        er;
        int          cyc, w0;
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", {24'd0, mem_wd}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        w0 = wn; e = 32'hDEADBEEF;
        xfer(1'b1, 3'b010, 32'h100, e, 0, rd, er, cyc);
        chk("sw_latency", cyc, 32'd5);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_nwrites", wn - w0, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("sw_addr", wa[w0+k], 32'h100 + k);
            chk("sw_data", {24'd0, wd[w0+k]}, {24'd0, e[8*k +: 8]});
        end

        xfer(1'b0, 3'b010, 32'h100, 32'd0, 0, rd, er, cyc);
        chk("lw", rd, 32'hDEADBEEF);
        chk("lw_latency", cyc, 32'd5);
        chk("lw_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 3'b000, 32'h103, 32'd0, 0, rd, er, cyc);
        chk("lb", rd, 32'hFFFFFFDE);
        chk("lb_latency", cyc, 32'd2);
        xfer(1'b0, 3'b100, 32'h103, 32'd0, 0, rd, er, cyc);
        chk("lbu", rd, 32'h000000DE);
        xfer(1'b0, 3'b001, 32'h102, 32'd0, 0, rd, er, cyc);
        chk("lh", rd, 32'hFFFFDEAD);
        chk("lh_latency", cyc, 32'd3);
        xfer(1'b0, 3'b101, 32'h100, 32'd0, 0, rd, er, cyc);
        chk("lhu", rd, 32'h0000BEEF);

        xfer(1'b0, 3'b010, 32'h100, 32'd0, 3, rd, er, cyc);
        chk("hold_lw", rd, 32'hDEADBEEF);
        chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, req_ready}, 32'd1);

        w0 = wn; e = 32'h11223344;
        xfer(1'b1, 3'b010, 32'h1FFFE, e, 0, rd, er, cyc);
`ifdef MISALIGN_TRAP_EN
        chk("wrap_err", {31'd0, er}, 32'd1);
        chk("wrap_latency", cyc, 32'd1);
        chk("wrap_nwrites", wn - w0, 32'd0);
        xfer(1'b0, 3'b001, 32'h101, 32'd0, 0, rd, er, cyc);
        chk("mis_lh_err", {31'd0, er}, 32'd1);
        chk("mis_lh_rdata", rd, 32'd0);
`else
        chk("wrap_err", {31'd0, er}, 32'd0);
        chk("wrap_nwrites", wn - w0, 32'd4);
        chk("wrap_a0", wa[w0], 32'h1FFFE);
        chk("wrap_a1", wa[w0+1], 32'h1FFFF);
        chk("wrap_a2", wa[w0+2], 32'h00000);
        chk("wrap_a3", wa[w0+3], 32'h00001);
        for (int k = 0; k < 4; k++) chk("wrap_data", {24'd0, wd[w0+k]}, {24'd0, e[8*k +: 8]});
        xfer(1'b0, 3'b010, 32'h1FFFE, 32'd0, 0, rd, er, cyc);
        chk("wrap_lw", rd, 32'h11223344);
        xfer(1'b0, 3'b001, 32'h101, 32'd0, 0, rd, er, cyc);
        chk("mis_lh", rd, 32'hFFFFADBE);
        chk("mis_lh_err", {31'd0, er}, 32'd0);
`endif

        w0 = wn;
        xfer(1'b1, 3'b011, 32'h100, 32'hCAFEF00D, 0, rd, er, cyc);
        chk("illegal_err", {31'd0, er}, 32'd1);
        chk("illegal_rdata", rd, 32'd0);
        chk("illegal_nwrites", wn - w0, 32'd0);
        chk("illegal_idle", {31'd0, req_ready}, 32'd1);

        w0 = wn;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h55667788;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        chk("abort_nwrites", wn - w0, 32'd1);
        chk("abort_byte0", {24'd0, mem[32'h200]}, 32'h88);
        chk("abort_byte1", {24'd0, mem[32'h201]}, 32'h00);
        xfer(1'b0, 3'b010, 32'h100, 32'd0, 0, rd, er, cyc);
        chk("abort_lw", rd, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
